counter_arbiter: RTL



---
 rtl/counter_arbiter.sv | 136 +++++++++++++
 1 files changed

// File: rtl/counter_arbiter.sv
// Round-robin arbiter sharing one saturating ticket counter between requesters.
// Optional grant-hold timeout is enabled by defining COUNTER_ARB_TIMEOUT_EN.
module counter_arbiter #(
  parameter int          Requesters = 4,
  parameter logic [31:0] Init       = 32'd8,
  parameter logic [31:0] Max        = 32'd64,
  parameter int          Timeout    = 16
) (
  input  logic                  Clk_i,
  input  logic                  Reset_n_i,
  input  logic [Requesters-1:0] Req_i,
  input  logic                  Clear_i,
  output logic [Requesters-1:0] Grant_o,
  output logic [31:0]           Data_o,
  output logic                  Sat_o,
  output logic                  Timeout_o
);

  localparam int PW = $clog2(Requesters);
  localparam logic [Requesters-1:0] ONE_REQ = {{(Requesters-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, GRANT, RELEASE} state_t;

  if (Requesters < 2 || Requesters > 8 || Timeout < 1 || Init > Max) begin : g_bad_param
    $error("counter_arbiter: illegal parameter set");
  end

  state_t                state_reg, state_next;
  logic [Requesters-1:0] grant_reg, grant_next;
  logic [31:0]           data_reg, data_next;
  logic                  sat_reg;
  logic [PW-1:0]         ptr_reg, ptr_next;
  logic [PW-1:0]         win_reg, win_next;
  logic                  timeout_reg, timeout_next;
  logic [PW-1:0]         cand_idx, win_idx, win_succ;
  logic                  win_found;
`ifdef COUNTER_ARB_TIMEOUT_EN
  logic [31:0]           hold_reg, hold_next;
`endif

  // Scan from the highest offset down so the lowest offset from the pointer wins.
  always_comb begin
    cand_idx  = '0;
    win_idx   = '0;
    win_found = 1'b0;
    for (int i = Requesters - 1; i >= 0; i--) begin
      cand_idx = PW'((int'(ptr_reg) + i) % Requesters);
      if (Req_i[cand_idx]) begin
        win_found = 1'b1;
        win_idx   = cand_idx;
      end
    end
  end

  assign win_succ = (win_reg == PW'(Requesters - 1)) ? '0 : win_reg + PW'(1);

  always_comb begin
    state_next   = state_reg;
    grant_next   = grant_reg;
    data_next    = data_reg;
    ptr_next     = ptr_reg;
    win_next     = win_reg;
    timeout_next = 1'b0;
`ifdef COUNTER_ARB_TIMEOUT_EN
    hold_next    = hold_reg;
`endif
    case (state_reg)
      IDLE: begin
        if (win_found) begin
          grant_next = ONE_REQ << win_idx;
          win_next   = win_idx;
          state_next = GRANT;
`ifdef COUNTER_ARB_TIMEOUT_EN
          hold_next  = '0;
`endif
        end
      end
      GRANT: begin
        if (!Req_i[win_reg]) begin
          grant_next = '0;
          ptr_next   = win_succ;
          state_next = RELEASE;
          if (data_reg < Max) data_next = data_reg + 32'd1;
`ifdef COUNTER_ARB_TIMEOUT_EN
        end else if (hold_reg >= 32'(Timeout - 1)) begin
          // Revoke: no ticket is consumed, the requester must re-request.
          grant_next   = '0;
          ptr_next     = win_succ;
          state_next   = RELEASE;
          timeout_next = 1'b1;
        end else begin
          hold_next = hold_reg + 32'd1;
`endif
        end
      end
      RELEASE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (Clear_i) data_next = Init;
  end

  always_ff @(posedge Clk_i or negedge Reset_n_i) begin
    if (!Reset_n_i) begin
      state_reg   <= IDLE;
      grant_reg   <= '0;
      data_reg    <= Init;
      sat_reg     <= (Init == Max);
      ptr_reg     <= '0;
      win_reg     <= '0;
      timeout_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      grant_reg   <= grant_next;
      data_reg    <= data_next;
      sat_reg     <= (data_next == Max);
      ptr_reg     <= ptr_next;
      win_reg     <= win_next;
      timeout_reg <= timeout_next;
    end
  end

`ifdef COUNTER_ARB_TIMEOUT_EN
  always_ff @(posedge Clk_i or negedge Reset_n_i) begin
    if (!Reset_n_i) hold_reg <= '0;
    else            hold_reg <= hold_next;
  end
  assign Timeout_o = timeout_reg;
`else
  assign Timeout_o = 1'b0;
`endif

  assign Grant_o = grant_reg;
  assign Data_o  = data_reg;
  assign Sat_o   = sat_reg;

endmodule
